step_ctrl: RTL and testbench

//  Execution controller upstream of the CPU core: turns a step push-button and a run switch

---
 rtl/cpu_pkg.sv | 8 +
 rtl/step_ctrl_debounce.sv | 44 ++++
 rtl/step_ctrl.sv | 124 ++++++++++++
 tb/tb_step_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU execution controller.
package cpu_pkg;

  typedef enum logic [1:0] {HALT, STEP_WAIT, RUN, BRK} ctrl_state_t;

  localparam int IP_W = 8;

endpackage

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced level
// only follows the synchronised input after CYCLES consecutive cycles of
// disagreement; a single agreeing cycle restarts the count.
module debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Metastability guard for the asynchronous board input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive disagreements; flip the level on the CYCLES-th one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES - 1)) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// Execution controller: turns a step button and a run switch into a one-cycle
// clock enable for the core. Single-steps in HALT, free-runs at a prescaled
// rate in RUN. Optional breakpoint stop enabled by defining STEP_CTRL_BP_EN.
module step_ctrl
  import cpu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIV         = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_step,
  input  logic            sw_run,
  input  logic [IP_W-1:0] ip,
  input  logic [IP_W-1:0] bp_addr,
  output logic            cpu_ce,
  output logic            running,
  output logic            bp_hit
);

  localparam int DW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

  logic          step_db, run_db, step_db_q, step_rise;
  ctrl_state_t   state, state_nx;
  logic          ce_nx;
  logic [DW-1:0] div;
  logic          wrap_q;

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .raw(btn_step), .level(step_db)
  );

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .raw(sw_run), .level(run_db)
  );

  assign step_rise = step_db & ~step_db_q;

`ifdef STEP_CTRL_BP_EN
  logic bp_match;
  assign bp_match = (ip == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{ip, bp_addr};
`endif

  // Next-state and pulse decision; run switch dominates the step button
  always_comb begin
    state_nx = state;
    ce_nx    = 1'b0;
    case (state)
      HALT: begin
        if (run_db) begin
          state_nx = RUN;
        end else if (step_rise) begin
          ce_nx    = 1'b1;
          state_nx = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        if (!step_db) state_nx = HALT;
      end
      RUN: begin
        if (!run_db) begin
          state_nx = HALT;
        end else if (wrap_q) begin
`ifdef STEP_CTRL_BP_EN
          if (bp_match) state_nx = BRK;
          else          ce_nx    = 1'b1;
`else
          ce_nx = 1'b1;
`endif
        end
      end
      BRK: begin
        if (!run_db) begin
          state_nx = HALT;
        end else if (step_rise) begin
          ce_nx    = 1'b1;
          state_nx = STEP_WAIT;
        end
      end
      default: state_nx = HALT;
    endcase
  end

  // State, registered enable and step edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HALT;
      cpu_ce    <= 1'b0;
      step_db_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_ce    <= ce_nx;
      step_db_q <= step_db;
    end
  end

  // Run-rate divider; held at zero outside RUN so every RUN entry starts clean.
  // wrap_q delays the pulse one cycle past the wrap, so the first pulse lands
  // RUN_DIV+1 cycles after entry and then every RUN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      wrap_q <= 1'b0;
    end else if (state == RUN && state_nx == RUN) begin
      div    <= (div == DIV_MAX) ? '0 : div + 1'b1;
      wrap_q <= (div == DIV_MAX);
    end else begin
      div    <= '0;
      wrap_q <= 1'b0;
    end
  end

  assign running = (state == RUN);
`ifdef STEP_CTRL_BP_EN
  assign bp_hit  = (state == BRK);
`else
  assign bp_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl: directed scenarios plus randomized button/switch
// activity, all checked every cycle against a history-based reference model.
module tb_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       sw_run = 1'b0;
  logic [7:0] ip = 8'h00;
  logic [7:0] bp_addr = 8'hFF;
  logic       cpu_ce, running, bp_hit;

  step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .sw_run(sw_run),
    .ip(ip), .bp_addr(bp_addr), .cpu_ce(cpu_ce), .running(running), .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: modes, time-in-RUN count and raw input histories
  localparam int M_HALT = 0, M_WAIT = 1, M_RUN = 2, M_BRK = 3;
  int mode;
  int since;
  bit m_sdb, m_rdb, m_rise, m_ce;
  bit qs[$];
  bit qr[$];

  // A debounced level flips once the four samples that have cleared the
  // synchroniser all disagree with it.
  function automatic bit settled(input bit q[$], input bit lvl);
    int sz = q.size();
    for (int k = 2; k <= 5; k++)
      if (q[sz-1-k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mode = M_HALT; since = 0;
    m_sdb = 0; m_rdb = 0; m_rise = 0; m_ce = 0;
    qs.delete(); qr.delete();
    repeat (6) begin qs.push_back(1'b0); qr.push_back(1'b0); end
  endtask

  task automatic model_edge();
    bit ce = 0;
    qs.push_back(btn_step);
    qr.push_back(sw_run);
    case (mode)
      M_HALT: begin
        if (m_rdb) begin mode = M_RUN; since = 0; end
        else if (m_rise) begin ce = 1; mode = M_WAIT; end
      end
      M_WAIT: if (!m_sdb) mode = M_HALT;
      M_RUN: begin
        if (!m_rdb) mode = M_HALT;
        else begin
          since++;
          if (since >= RD + 1 && (since - (RD + 1)) % RD == 0) begin
`ifdef STEP_CTRL_BP_EN
            if (ip == bp_addr) mode = M_BRK;
            else ce = 1;
`else
            ce = 1;
`endif
          end
        end
      end
      default: begin
        if (!m_rdb) mode = M_HALT;
        else if (m_rise) begin ce = 1; mode = M_WAIT; end
      end
    endcase
    m_ce = ce;
    m_rise = 0;
    if (settled(qs, m_sdb)) begin m_sdb = !m_sdb; m_rise = m_sdb; end
    if (settled(qr, m_rdb)) m_rdb = !m_rdb;
    while (qs.size() > 8) begin void'(qs.pop_front()); void'(qr.pop_front()); end
  endtask

  // One clock: model at the rising edge, compare at the falling edge,
  // then the "core" advances ip on an enable.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    chk("cpu_ce", cpu_ce, m_ce);
    chk("running", running, (mode == M_RUN));
    chk("bp_hit", bp_hit, (mode == M_BRK));
    if (cpu_ce) pulses++;
    if (m_ce) ip = ip + 8'd1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  int lat, run_lat, ce_lat, prev, hs, hr;
  bit found;

  initial begin
    model_reset();
    // 1. reset with both inputs asserted
    btn_step = 1'b1; sw_run = 1'b1; rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ce", cpu_ce, 0);
    chk("rst_running", running, 0);
    chk("rst_bp", bp_hit, 0);
    btn_step = 1'b0; sw_run = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // 2. clean step press
    pulses = 0; lat = -1;
    btn_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ce && lat < 0) lat = i;
    end
    btn_step = 1'b0;
    repeat (15) tick();
    chk("step_lat", lat, 7);
    chk("step_cnt", pulses, 1);

    // 3. bouncing button
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      repeat (2) tick();
    end
    btn_step = 1'b0;
    repeat (15) tick();
    chk("bounce_cnt", pulses, 0);

    // 4. run mode
    pulses = 0; run_lat = -1; ce_lat = -1; prev = -1;
    sw_run = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (running && run_lat < 0) run_lat = i;
      if (cpu_ce) begin
        if (ce_lat < 0) ce_lat = i - run_lat;
        else chk("run_period", i - prev, RD);
        prev = i;
      end
    end
    chk("run_lat", run_lat, 7);
    chk("run_first", ce_lat, RD + 1);
    chk("run_cnt", pulses, 11);
    sw_run = 1'b0;
    repeat (10) tick();
    chk("run_off", running, 0);
    pulses = 0;
    repeat (20) tick();
    chk("run_off_cnt", pulses, 0);

    // 5. breakpoint
    do_reset();
    ip = 8'h00; bp_addr = 8'h05; pulses = 0;
    sw_run = 1'b1;
`ifdef STEP_CTRL_BP_EN
    for (int i = 0; i < 200 && !bp_hit; i++) tick();
    chk("bp_pulses", pulses, 5);
    chk("bp_hit", bp_hit, 1);
    chk("bp_running", running, 0);
    pulses = 0;
    btn_step = 1'b1;
    repeat (15) tick();
    chk("bp_step_cnt", pulses, 1);
    chk("bp_wait_hit", bp_hit, 0);
    chk("bp_wait_run", running, 0);
    btn_step = 1'b0; sw_run = 1'b0;
    repeat (12) tick();
    chk("bp_halt_run", running, 0);
    chk("bp_halt_hit", bp_hit, 0);
    chk("bp_halt_cnt", pulses, 1);
`else
    repeat (80) tick();
    chk("nobp_hit", bp_hit, 0);
    chk("nobp_running", running, 1);
    chk("nobp_pulses", (pulses > 5), 1);
    sw_run = 1'b0;
    repeat (12) tick();
`endif

    // 6. async reset while the enable is high
    do_reset();
    bp_addr = 8'hFF; ip = 8'h00;
    sw_run = 1'b1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (cpu_ce) found = 1;
    end
    chk("arst_found", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ce", cpu_ce, 0);
    chk("arst_running", running, 0);
    sw_run = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (15) tick();
    chk("arst_halt", running, 0);
    chk("arst_cnt", pulses, 0);

    // 7. randomized button/switch activity
    do_reset();
    bp_addr = 8'($urandom_range(0, 40));
    hs = 0; hr = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hs == 0) begin btn_step = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 10); end
      if (hr == 0) begin sw_run = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 40); end
      hs--; hr--;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
